// File: rtl/uart_cmd_responder_if.sv
// Byte handshake between the UART rx/tx pair and the command responder.
// master is the UART side; slave is the responder.
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output rx_data,
    output rx_done,
    output tx_done,
    input  tx_data,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  tx_done,
    output tx_data,
    output tx_start
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART register-access command responder (write 0x57, read 0x52).
// Define UART_RESP_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES.
module uart_cmd_responder #(
  parameter int NREGS          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cmd_responder_if.slave  bus,
  output logic                 busy,
  output logic                 rx_drop,
  output logic [8*NREGS-1:0]   reg_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  if (NREGS < 1 || NREGS > 256 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_cmd_responder: illegal parameters");
  end

  logic [2:0] state;
  logic       is_wr;
  logic [7:0] addr;
  logic [7:0] rd_val;
  logic       rx_ok;
  logic       addr_ok;
  logic       tmo;

  // Full 8-bit compare: out-of-range addresses must never alias.
  assign rx_ok   = {1'b0, bus.rx_data} < 9'(NREGS);
  assign addr_ok = {1'b0, addr} < 9'(NREGS);
  assign busy    = (state != S_IDLE);

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if (bus.rx_data == 8'(k)) rd_val = reg_out[8*k +: 8];
    end
  end

`ifdef UART_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic          in_frame;

  assign in_frame = (state == S_ADDR) || (state == S_DATA);
  assign tmo = in_frame && !bus.rx_done &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (!in_frame || bus.rx_done || tmo) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      is_wr        <= 1'b0;
      addr         <= 8'h00;
      bus.tx_data  <= 8'h00;
      bus.tx_start <= 1'b0;
      rx_drop      <= 1'b0;
      reg_out      <= '0;
    end else begin
      bus.tx_start <= 1'b0;
      rx_drop      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.rx_done) begin
            unique case (1'b1)
              bus.rx_data == OP_WR: begin
                is_wr <= 1'b1;
                state <= S_ADDR;
              end
              bus.rx_data == OP_RD: begin
                is_wr <= 1'b0;
                state <= S_ADDR;
              end
              default: begin
                bus.tx_data <= NAK;
                state       <= S_SEND;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (bus.rx_done) begin
            addr <= bus.rx_data;
            if (is_wr) begin
              state <= S_DATA;
            end else begin
              bus.tx_data <= rx_ok ? rd_val : NAK;
              state       <= S_SEND;
            end
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (bus.rx_done) begin
            for (int k = 0; k < NREGS; k++) begin
              if (addr == 8'(k)) reg_out[8*k +: 8] <= bus.rx_data;
            end
            bus.tx_data <= addr_ok ? ACK : NAK;
            state       <= S_SEND;
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          bus.tx_start <= 1'b1;
          rx_drop      <= bus.rx_done;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          rx_drop <= bus.rx_done;
          if (bus.tx_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder (NREGS=4, TIMEOUT_CYCLES=50).
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        rx_drop;
  logic [31:0] reg_out;

  uart_cmd_responder_if bus ();

  uart_cmd_responder #(
    .NREGS          (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .rx_drop (rx_drop),
    .reg_out (reg_out)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         drops  = 0;
  logic [7:0] expq[$];
  logic [7:0] model[4];
  logic       done_seen  = 1'b0;
  logic       prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Monitor: every tx_start pops one expected response.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.tx_start) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx act=%h exp=none", bus.tx_data);
        end else begin
          check("tx_data", {24'h0, bus.tx_data}, {24'h0, expq.pop_front()});
        end
        check("busy_at_start", {31'h0, busy}, 32'd1);
      end
      if (prev_start) check("start_width", {31'h0, bus.tx_start}, 32'd0);
      if (done_seen) check("idle_after_done", {31'h0, busy}, 32'd0);
      if (rx_drop) drops++;
      prev_start = bus.tx_start;
      done_seen  = bus.tx_done;
    end else begin
      prev_start = 1'b0;
      done_seen  = 1'b0;
    end
  end

  // Transmitter model: finish each byte a few cycles after tx_start.
  always begin
    @(negedge clk);
    if (reset && bus.tx_start) begin
      repeat (5) @(posedge clk);
      #1 bus.tx_done = 1'b1;
      @(posedge clk);
      #1 bus.tx_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1 bus.rx_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !bus.tx_done) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle act=busy exp=idle");
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    if (a < 8'd4) begin
      expq.push_back(8'h06);
      model[a[1:0]] = d;
    end else begin
      expq.push_back(8'h15);
    end
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
    @(negedge clk);
    check("reg_out_n1", reg_out, flat());
    check("busy_n1", {31'h0, busy}, 32'd1);
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    expq.push_back(a < 8'd4 ? model[a[1:0]] : 8'h15);
    send_byte(8'h52);
    send_byte(a);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rx_drop", {31'h0, rx_drop}, 32'h0);
    check("rst_reg_out", reg_out, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    do_write(8'h02, 8'hA5);
    do_read(8'h02);
    check("reg_out_a5", reg_out, 32'h00A5_0000);

    expq.push_back(8'h15);
    send_byte(8'h41);
    wait_idle();
    do_read(8'h02);

    do_write(8'h04, 8'h11);
    check("bad_wr_unchanged", reg_out, 32'h00A5_0000);
    do_read(8'hFF);
    do_read(8'h04);
    do_write(8'h03, 8'h5A);
    do_write(8'h00, 8'hC3);
    do_read(8'h03);
    do_read(8'h00);
    check("reg_out_mix", reg_out, 32'h5AA5_00C3);

    expq.push_back(8'h06);
    model[1] = 8'h3C;
    d0 = drops;
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'h3C);
    @(posedge clk);
    #1;
    bus.rx_data = 8'h52;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1 bus.rx_done = 1'b0;
    wait_idle();
    check("rx_drop_count", drops - d0, 32'd1);
    do_read(8'h01);

    send_byte(8'h57);
    send_byte(8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("mid_rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rx_drop", {31'h0, rx_drop}, 32'h0);
    check("mid_rst_reg_out", reg_out, 32'h0);
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(posedge clk);
    #1 reset = 1'b1;
    do_read(8'h00);

    send_byte(8'h57);
    send_byte(8'h01);
    repeat (60) @(posedge clk);
    @(negedge clk);
`ifdef UART_RESP_TIMEOUT_EN
    check("timeout_idle", {31'h0, busy}, 32'd0);
    do_read(8'h01);
    check("timeout_no_write", reg_out, 32'h0);
`else
    check("no_timeout_busy", {31'h0, busy}, 32'd1);
    expq.push_back(8'h06);
    model[1] = 8'h77;
    send_byte(8'h77);
    wait_idle();
    check("late_write", reg_out, 32'h0000_7700);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder sitting behind the UART receiver and in front of the UART transmitter. Parses framed register-access commands from `rx_data`/`rx_done`, executes them against a small internal register file, and returns exactly one response byte per complete frame via `tx_data`/`tx_start`/`tx_done`. Register contents are exported as a flat bus for use by the host design.

## Interface
- `NREGS`, 4: number of 8-bit registers; legal addresses are 0..NREGS-1; range 1..256.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout in `clk` cycles; must be ≥ 2; used only when the `UART_RESP_TIMEOUT_EN` macro is defined.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid while `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse: new byte on `rx_data`.
- `tx_done`  in  1  one-cycle pulse from the transmitter: response byte fully sent.
- `tx_data`  out  8  response byte; held stable from `tx_start` until `tx_done`.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `busy`  out  1  high in every state except IDLE.
- `rx_drop`  out  1  one-cycle pulse: byte arrived in SEND/WAIT_TX and was discarded.
- `reg_out`  out  8*NREGS  register file; register k is `reg_out[8k+7:8k]`.

## Operation
- Frames:
  - Write: 0x57, addr, data → response 0x06 (ACK).
  - Read: 0x52, addr → response is `reg[addr]`.
- Any other first byte → response 0x15 (NAK) immediately; no further bytes are consumed.
- addr ≥ NREGS → NAK after the frame completes. For a bad write, the data byte is still consumed and no register changes.
- FSM states:
  - IDLE: on `rx_done`, decode the opcode. 0x57/0x52 → GET_ADDR; anything else → SEND with NAK.
  - GET_ADDR: on `rx_done`, latch addr. Write → GET_DATA; read → SEND with `reg[addr]` or NAK.
  - GET_DATA: on `rx_done`, perform the write if addr is valid → SEND with ACK or NAK.
  - SEND: assert `tx_start` for one cycle → WAIT_TX.
  - WAIT_TX: on `tx_done` → IDLE.
- `rx_done` in SEND or WAIT_TX: byte discarded and `rx_drop` pulses; no state change.
- Address compare uses the full 8-bit addr, with no truncation or wrap. For example, with NREGS=4, addr 0x04 gives NAK, not reg0.
- Reset values:
  - All registers 0x00; `reg_out`=0.
  - `tx_data`=0x00, `tx_start`=0, `busy`=0, `rx_drop`=0.
  - State IDLE; timeout counter 0.
- Reset mid-frame or mid-transmission aborts immediately. No response is issued for the aborted frame.

## Timing
- The cycle on which the final frame byte's `rx_done` is sampled is cycle N.
- Cycle N+1:
  - State is SEND and `tx_data` holds the response.
  - For a valid write, `reg_out` shows the new value.
  - `busy`=1.
- Cycle N+2: `tx_start`=1 for exactly this one cycle.
- Read data is sampled at cycle N, so a read returns the register value present when the addr byte arrives.
- `tx_data` holds its value until the next response is loaded.
- The cycle after `tx_done` is sampled, the block is in IDLE and `busy`=0. `rx_done` sampled in that cycle starts a new frame.
- `tx_done` outside WAIT_TX is ignored.

## Configuration
- Macro: `UART_RESP_TIMEOUT_EN`.
- Defined:
  - In GET_ADDR and GET_DATA, a counter increments every cycle and clears on each `rx_done`.
  - When it reaches TIMEOUT_CYCLES-1 without `rx_done`, the FSM returns to IDLE with no response. Any partial frame is discarded and no register is modified.
  - The counter is held at 0 in all other states.
- Undefined: no counter is built; partial frames wait indefinitely.

## Test plan
- After reset, send 0x57,0x02,0xA5 then 0x52,0x02. Required:
  - Responses are 0x06, then 0xA5.
  - `reg_out[23:16]`=0xA5 and all other registers are 0x00.
- Send 0x41 → a single NAK 0x15. The next byte, 0x52, is treated as a new opcode.
- Send 0x57,0x04,0x11 with NREGS=4 → NAK 0x15; `reg_out` unchanged.
- Inject `rx_done` during WAIT_TX → `rx_drop` pulses once; the response in flight is unaffected; state returns to IDLE on `tx_done`.
- With `UART_RESP_TIMEOUT_EN` and TIMEOUT_CYCLES=50: send 0x57,0x01, then idle 60 cycles, then 0x52,0x01 → a single response 0x00, with no write performed.
- Assert `reset` low mid-frame after 0x57,0x00 → outputs at reset values. A subsequent 0x52,0x00 returns 0x00.
